// File: rtl/conway_sequencer.sv
// Generation sequencer for a Conway life board: load, single-step and free-run control.
// Optional stall detection (board stops changing -> HALT) is enabled by defining CONWAY_STALL_DETECT_EN.
module conway_sequencer #(
  parameter int CELLS    = 64,
  parameter int PERIOD_W = 24,
  parameter int GEN_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                run,
  input  logic                step,
  input  logic [PERIOD_W-1:0] period,
  input  logic [CELLS-1:0]    board_q,
  input  logic [CELLS-1:0]    board_d,
  output logic                cells_rst,
  output logic                cells_ena,
  output logic [GEN_W-1:0]    gen_count,
  output logic                running,
  output logic                stable
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_TICK,
    S_HALT
  } state_t;

  state_t              state_q, state_d;
  logic [PERIOD_W-1:0] div_q, div_d;
  logic [PERIOD_W:0]   div_inc;
  logic [GEN_W-1:0]    gen_q, gen_d;
  logic                arm_q, arm_d;
  logic                stable_q, stable_d;
  logic                stall;

`ifdef CONWAY_STALL_DETECT_EN
  assign stall  = (board_d == board_q);
  assign stable = stable_q;
`else
  logic unused_cfg;
  assign stall      = 1'b0;
  assign stable     = 1'b0;
  assign unused_cfg = ^{board_q, board_d, stable_q};
`endif

  // Divider is compared after its increment, so WAIT lasts max(period,1) cycles
  // and strobes land period+1 apart; >= also covers period being lowered mid-count.
  assign div_inc = {1'b0, div_q} + 1'b1;

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    gen_d    = gen_q;
    arm_d    = arm_q;
    stable_d = stable_q;
    // A held step re-arms only once it has been released.
    if (!step) arm_d = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          state_d = S_LOAD;
        end else if (run) begin
          state_d = S_WAIT;
          div_d   = '0;
        end else if (step && arm_q) begin
          state_d = S_TICK;
          arm_d   = 1'b0;
        end
      end
      S_LOAD: state_d = S_IDLE;
      S_WAIT: begin
        if (load) begin
          state_d = S_LOAD;
        end else if (!run) begin
          state_d = S_IDLE;
          div_d   = '0;
        end else begin
          div_d = div_inc[PERIOD_W-1:0];
          if (div_inc >= {1'b0, period}) state_d = S_TICK;
        end
      end
      S_TICK: begin
        if (gen_q != {GEN_W{1'b1}}) gen_d = gen_q + 1'b1;
        div_d = '0;
        if (load) begin
          state_d = S_LOAD;
        end else if (stall) begin
          state_d  = S_HALT;
          stable_d = 1'b1;
        end else if (run) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HALT: if (load) state_d = S_LOAD;
      default: state_d = S_IDLE;
    endcase
    // Clear on entry so LOAD already shows a fresh count.
    if (state_d == S_LOAD) begin
      gen_d    = '0;
      div_d    = '0;
      stable_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      gen_q     <= '0;
      arm_q     <= 1'b1;
      stable_q  <= 1'b0;
      cells_rst <= 1'b0;
      cells_ena <= 1'b0;
      running   <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      gen_q     <= gen_d;
      arm_q     <= arm_d;
      stable_q  <= stable_d;
      cells_rst <= (state_d == S_LOAD);
      cells_ena <= (state_d == S_TICK);
      running   <= (state_d == S_WAIT) || (state_d == S_TICK);
    end
  end

  assign gen_count = gen_q;

endmodule

// File: tb/tb_conway_sequencer.sv
// Directed self-checking bench for conway_sequencer (default and stall-detect builds).
module tb_conway_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load = 1'b0, run = 1'b0, step = 1'b0;
  logic [23:0] period = 24'd3;
  logic [63:0] bq = 64'hA5A5_0F0F_3C3C_9696;
  logic [63:0] bd = 64'h5A5A_F0F0_C3C3_6969;
  logic        cells_rst, cells_ena, running, stable;
  logic [15:0] gen_count;
  logic        cells_rst4, cells_ena4, running4, stable4;
  logic [3:0]  gen_count4;

  int total = 0, bad = 0;
  int cyc = 0, ena_cnt = 0, last_pulse = 0, gap = 0;
  int base;

  conway_sequencer u_dut (
    .clk(clk), .rst(rst), .load(load), .run(run), .step(step), .period(period),
    .board_q(bq), .board_d(bd), .cells_rst(cells_rst), .cells_ena(cells_ena),
    .gen_count(gen_count), .running(running), .stable(stable)
  );

  conway_sequencer #(.GEN_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .load(load), .run(run), .step(step), .period(period),
    .board_q(bq), .board_d(bd), .cells_rst(cells_rst4), .cells_ena(cells_ena4),
    .gen_count(gen_count4), .running(running4), .stable(stable4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (cells_ena) begin
      ena_cnt++;
      gap        = cyc - last_pulse;
      last_pulse = cyc;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic do_load();
    load = 1'b1;
    @(negedge clk);
    chk("load_rst_hi", cells_rst, 1);
    chk("load_gen_clr", gen_count, 0);
    chk("load_stable_clr", stable, 0);
    load = 1'b0;
    @(negedge clk);
    chk("load_rst_lo", cells_rst, 0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cells_rst", cells_rst, 0);
    chk("rst_cells_ena", cells_ena, 0);
    chk("rst_running", running, 0);
    chk("rst_gen", gen_count, 0);
    chk("rst_stable", stable, 0);
    rst = 1'b1;
    @(negedge clk);

    // Single-cycle load pulse
    do_load();
    chk("idle_after_load", running, 0);

    // Free run, period 3, run sampled on 20 edges
    period = 24'd3;
    base = ena_cnt;
    run = 1'b1;
    repeat (20) @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    chk("run_pulses", ena_cnt - base, 5);
    chk("run_gap", gap, 4);
    chk("run_gen", gen_count, 5);
    chk("run_stopped", running, 0);

    // Held step gives one generation
    base = ena_cnt;
    step = 1'b1;
    repeat (10) @(negedge clk);
    step = 1'b0;
    @(negedge clk);
    chk("step_pulses", ena_cnt - base, 1);
    chk("step_gen", gen_count, 6);

    // load + run + step together: LOAD wins
    load = 1'b1; run = 1'b1; step = 1'b1;
    @(negedge clk);
    chk("prio_rst", cells_rst, 1);
    chk("prio_ena", cells_ena, 0);
    chk("prio_gen", gen_count, 0);
    load = 1'b0; step = 1'b0;
    @(negedge clk);
    chk("prio_idle", running, 0);
    @(negedge clk);
    chk("prio_wait", running, 1);
    chk("prio_wait_ena", cells_ena, 0);
    run = 1'b0;
    @(negedge clk);
    chk("wait_to_idle", running, 0);

    // period 0: strobe every other cycle; 4-bit counter saturates
    period = 24'd0;
    base = ena_cnt;
    run = 1'b1;
    repeat (40) @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    chk("p0_gap", gap, 2);
    chk("p0_pulses", ena_cnt - base, 20);
    chk("p0_gen", gen_count, 20);
    chk("sat_gen4", gen_count4, 15);

    // Board stops changing at a TICK
    bd = bq;
    step = 1'b1;
    @(negedge clk);
    chk("stall_tick", cells_ena, 1);
    step = 1'b0;
    @(negedge clk);
    chk("stall_gen", gen_count, 21);
`ifdef CONWAY_STALL_DETECT_EN
    chk("stall_stable", stable, 1);
    chk("stall_running", running, 0);
`else
    chk("nostall_stable", stable, 0);
`endif
    base = ena_cnt;
    run = 1'b1;
    repeat (8) @(negedge clk);
    run = 1'b0;
    @(negedge clk);
`ifdef CONWAY_STALL_DETECT_EN
    chk("halt_no_ena", ena_cnt - base, 0);
    chk("halt_stable_held", stable, 1);
    chk("halt_gen", gen_count, 21);
`else
    chk("nohalt_ena", ena_cnt - base, 4);
    chk("nohalt_gen", gen_count, 25);
`endif
    bd = ~bq;
    do_load();

    // Asynchronous reset during WAIT
    period = 24'd3;
    run = 1'b1;
    repeat (6) @(negedge clk);
    chk("pre_rst_running", running, 1);
    chk("pre_rst_gen", gen_count, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_running", running, 0);
    chk("arst_ena", cells_ena, 0);
    chk("arst_cells_rst", cells_rst, 0);
    chk("arst_gen", gen_count, 0);
    chk("arst_stable", stable, 0);
    run = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    load = 1'b1;
    @(negedge clk);
    chk("first_edge_load", cells_rst, 1);
    load = 1'b0;
    @(negedge clk);
    chk("first_edge_done", cells_rst, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/conway_sequencer.md
CONWAY_SEQUENCER -- requirements
Module: conway_sequencer

Interface
REQ-001 SHALL have parameter CELLS, default 64: number of cells in the board.
REQ-002 SHALL have parameter PERIOD_W, default 24: width of the generation period.
REQ-003 SHALL have parameter GEN_W, default 16: width of the generation counter.
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port load, input, 1: request to load the initial board.
REQ-007 SHALL have port run, input, 1: level; free-run generations while high.
REQ-008 SHALL have port step, input, 1: request to advance exactly one generation.
REQ-009 SHALL have port period, input, PERIOD_W: idle cycles between generations in free-run.
REQ-010 SHALL have port board_q, input, CELLS: current state of all cells.
REQ-011 SHALL have port board_d, input, CELLS: next state of all cells.
REQ-012 SHALL have port cells_rst, output, 1: makes every cell take its initial state on the next edge.
REQ-013 SHALL have port cells_ena, output, 1: one-cycle strobe that advances one generation.
REQ-014 SHALL have port gen_count, output, GEN_W: generations completed since the last load.
REQ-015 SHALL have port running, output, 1: high while in WAIT or TICK.
REQ-016 SHALL have port stable, output, 1: the board has stopped changing.

Function
REQ-017 SHALL implement five states: IDLE, LOAD, WAIT, TICK and HALT.
REQ-018 SHALL drive cells_rst, cells_ena and running as registered Moore outputs, with cells_rst=1 only in LOAD and cells_ena=1 only in TICK; the two SHALL never be high together.
REQ-019 SHALL give requests the priority load > run > step when they arrive in the same cycle.
REQ-020 SHALL enter LOAD on the next edge when load=1 in IDLE, WAIT or HALT; load in TICK SHALL take effect on the edge after TICK.
REQ-021 SHALL stay in LOAD for exactly 1 cycle, then go to IDLE.
REQ-022 SHALL, in LOAD, clear gen_count, the divider and stable.
REQ-023 SHALL, in IDLE with run=1, go to WAIT with the divider at 0.
REQ-024 SHALL, in IDLE with run=0 and step=1, go to TICK on the next edge; a level-held step SHALL produce only one TICK per return to IDLE.
REQ-025 SHALL ignore step outside IDLE.
REQ-026 SHALL, in WAIT, increment the divider every cycle and go to TICK when divider == period (compared live), giving a strobe spacing of period+1 cycles; period=0 SHALL give a strobe every other cycle.
REQ-027 SHALL, in WAIT with run=0, go to IDLE and clear the divider.
REQ-028 SHALL, in TICK, increment gen_count (saturating at all-ones, never wrapping) and clear the divider.
REQ-029 SHALL leave TICK for WAIT if run=1, otherwise for IDLE.
REQ-030 SHALL leave HALT only through load.

Reset
REQ-031 SHALL, while rst=0, immediately force state=IDLE, divider=0, gen_count=0, cells_rst=0, cells_ena=0, running=0 and stable=0, with no clock required.
REQ-032 SHALL abandon any in-progress operation on reset; a TICK interrupted mid-cycle SHALL NOT count.
REQ-033 SHALL respond to the first request on the first clock edge after rst returns high.

Configuration
REQ-034 SHALL, when CONWAY_STALL_DETECT_EN is defined, compare board_d with board_q in TICK; on a match it SHALL set stable=1 (held until load or reset) and go to HALT instead of WAIT/IDLE.
REQ-035 SHALL, when CONWAY_STALL_DETECT_EN is undefined, tie stable to 0, never enter HALT, and leave board_q/board_d present but unused.

Verification
REQ-036 SHALL cover: reset release, then load=1 for 1 cycle -> cells_rst=1 for exactly 1 cycle, gen_count=0, state IDLE.
REQ-037 SHALL cover: period=3, run held for 20 cycles -> cells_ena pulses every 4 cycles, gen_count=5 after run drops.
REQ-038 SHALL cover: step held high for 10 cycles in IDLE -> exactly one cells_ena pulse, gen_count increments by 1.
REQ-039 SHALL cover: load, run and step asserted in the same cycle -> LOAD wins, no cells_ena that cycle, then WAIT on the next request.
REQ-040 SHALL cover: GEN_W=4 with 20 generations -> gen_count saturates at 15.
REQ-041 SHALL cover, with CONWAY_STALL_DETECT_EN: board_d==board_q at a TICK -> stable=1, running=0, no further cells_ena until load; rst=0 during WAIT -> all outputs 0 asynchronously.
